rf_wport_arbiter: RTL and testbench
===================================

// Module: rf_wport_arbiter
// PURPOSE
// Owns the single register-file write port behind the WB stage and shares it between
// the in-order pipeline writeback (fixed priority) and a long-latency execution unit
// (divider/multiplier result return). Losing unit results wait in a small in-order FIFO.
// Exports a pending-destination bitmap so ID can interlock on results still queued.
// PARAMETERS
// DEPTH      4   unit-result FIFO entries (power of 2, >=2)
// STARVE_MAX 8   cycles a valid FIFO head may wait before the pipe is stalled
// PORTS
// clk          in   1   clock, all state on posedge
// rst          in   1   synchronous reset, active-high
// pipe_we      in   1   WB commit write request (already qualified by valid/exception)
// pipe_waddr   in   5   WB destination register
// pipe_wdata   in   32  WB write data
// pipe_stall   out  1   WB must hold; pipe_we is ignored while this is 1
// au_valid     in   1   unit result valid
// au_ready     out  1   unit result accepted when au_valid&au_ready
// au_waddr     in   5   unit destination register
// au_wdata     in   32  unit result data
// flush        in   1   WB exception/ertn flush; discards all queued unit results
// rf_we        out  1   register-file write enable
// rf_waddr     out  5   register-file write address
// rf_wdata     out  32  register-file write data
// pending      out  32  bit n=1 iff a live FIFO entry targets rn; bit 0 always 0
// BEHAVIOUR
// - Reset: FIFO empty, head-wait counter 0, state NORMAL; rf_we=0, rf_waddr=0,
//   rf_wdata=0, pipe_stall=0, au_ready=0 while rst=1, pending=0.
// - au_ready = ~rst & (count<DEPTH) & ~flush. Combinational; no dependence on au_valid.
// - States: NORMAL, FORCE. NORMAL->FORCE when FIFO head is live and wait counter
//   reaches STARVE_MAX; FORCE->NORMAL on the cycle the head is written. flush or
//   rst -> NORMAL. pipe_stall = (state==FORCE).
// - Port selection per cycle, combinational (zero latency), priority order:
//   1) FORCE: write FIFO head. 2) pipe_we & ~pipe_stall: write pipe.
//   3) FIFO non-empty: write head. 4) FIFO empty & accepted au: cut-through write au.
//   5) otherwise rf_we=0 (rf_waddr/rf_wdata=0).
// - An accepted au result not written via cut-through is pushed at tail same cycle.
// - Head written or dead => popped that cycle; dead heads pop without asserting rf_we.
// - Any write to r0 (either source) is suppressed (rf_we=0), but still consumes/pops.
// - WAW kill: when the pipe writes rX (X!=0), every FIFO entry with waddr==X, and an
//   au result accepted that same cycle with waddr==X, is marked dead (pipe is newer).
// - Wait counter: increments each cycle the head is live and not written; clears on
//   pop, flush, empty. Saturates at STARVE_MAX.
// - flush: all entries dead and FIFO emptied next cycle; au result offered in the flush
//   cycle not accepted; rf write selected in the flush cycle still occurs (pipe_we is
//   already 0 from WB on an excepting instruction).
// - Simultaneous push and pop when full: not possible (au_ready=0 when full); push and
//   pop in same cycle otherwise keep count unchanged. Pointers wrap mod DEPTH.
// - pending reflects registered FIFO contents only (excludes same-cycle accepts).
// TESTING
// 1) Reset 3 cycles, au_valid=1 -> au_ready=0, rf_we=0, pending=0 throughout reset.
// 2) Empty FIFO, au r5=0x11 alone -> same cycle rf_we=1 waddr=5 wdata=0x11, no push.
// 3) pipe_we r3 every cycle, au r7 offered -> r7 queued, pending[7]=1; after 8 waiting
//    cycles pipe_stall=1, next rf write is r7, then pipe_stall=0, pending=0.
// 4) Queue r9=0xA, then pipe writes r9=0xB -> r9 entry dead, never written; rf sees 0xB only.
// 5) Fill DEPTH=4 entries while pipe busy -> au_ready=0; one pop -> au_ready=1.
// 6) FIFO holding 3 live entries, flush=1 -> next cycle pending=0, no unit writes issued.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: the WB pipeline has fixed priority and long-latency unit
// results queue in a small in-order FIFO. A pending bitmap lets ID interlock on queued results.
module rf_wport_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        au_valid,
    output logic        au_ready,
    input  logic [4:0]  au_waddr,
    input  logic [31:0] au_wdata,
    input  logic        flush,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(STARVE_MAX);

    typedef enum logic {
        NORMAL,
        FORCE
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WW-1:0]    waitCnt_q, waitCnt_d;
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       fifoAddr_q [DEPTH];
    logic [31:0]      fifoData_q [DEPTH];

    logic        fifoEmpty;
    logic        headLive;
    logic [4:0]  headAddr;
    logic [31:0] headData;
    logic        auReady;
    logic        auAccept;
    logic        selHead;
    logic        selPipe;
    logic        selAu;
    logic        headPop;
    logic        push;
    logic        pipeKill;
    logic [31:0] pendingVec;

    // A slot's live bit is cleared when it pops, so an empty FIFO never reports a live head.
    assign fifoEmpty = (count_q == '0);
    assign headAddr  = fifoAddr_q[rdPtr_q];
    assign headData  = fifoData_q[rdPtr_q];
    assign headLive  = live_q[rdPtr_q];

    assign auReady  = ~rst & (count_q < FULL_COUNT) & ~flush;
    assign auAccept = au_valid & auReady;
    assign au_ready = auReady;

    assign pipe_stall = ~rst & (state_q == FORCE);

    always_comb begin
        selHead = 1'b0;
        selPipe = 1'b0;
        selAu   = 1'b0;
        if (state_q == FORCE) begin
            selHead = 1'b1;
        end else if (pipe_we) begin
            selPipe = 1'b1;
        end else if (!fifoEmpty) begin
            selHead = 1'b1;
        end else if (auAccept) begin
            selAu = 1'b1;
        end
    end

    // Dead heads drain on their own, even while the pipe owns the port.
    assign headPop  = ~fifoEmpty & (selHead | ~headLive);
    assign push     = auAccept & ~selAu;
    assign pipeKill = selPipe & (pipe_waddr != 5'd0);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (selHead && headLive && (headAddr != 5'd0)) begin
                rf_we    = 1'b1;
                rf_waddr = headAddr;
                rf_wdata = headData;
            end else if (selPipe && (pipe_waddr != 5'd0)) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_waddr;
                rf_wdata = pipe_wdata;
            end else if (selAu && (au_waddr != 5'd0)) begin
                rf_we    = 1'b1;
                rf_waddr = au_waddr;
                rf_wdata = au_wdata;
            end
        end
    end

    // A pipe write is younger than anything queued, so same-register unit results die.
    always_comb begin
        live_d  = live_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (pipeKill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fifoAddr_q[i] == pipe_waddr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (headPop) begin
            live_d[rdPtr_q] = 1'b0;
            rdPtr_d         = rdPtr_q + PW'(1);
        end
        if (push) begin
            live_d[wrPtr_q] = ~(pipeKill && (au_waddr == pipe_waddr));
            wrPtr_d         = wrPtr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(headPop);
        if (flush) begin
            live_d  = '0;
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end
    end

    always_comb begin
        waitCnt_d = waitCnt_q;
        if (flush || headPop || fifoEmpty) begin
            waitCnt_d = '0;
        end else if (headLive && !selHead && (waitCnt_q != WAIT_MAX)) begin
            waitCnt_d = waitCnt_q + WW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                if (!flush && live_d[rdPtr_q] && (waitCnt_d == WAIT_MAX)) begin
                    state_d = FORCE;
                end
            end
            FORCE: begin
                if (flush || headPop) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_comb begin
        pendingVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pendingVec[fifoAddr_q[i]] = 1'b1;
            end
        end
        pendingVec[0] = 1'b0;
    end

    assign pending = rst ? 32'd0 : pendingVec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NORMAL;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            waitCnt_q <= '0;
            live_q    <= '0;
        end else begin
            state_q   <= state_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            waitCnt_q <= waitCnt_d;
            live_q    <= live_d;
        end
    end

    // Payload storage needs no reset; the live bits decide what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr_q[wrPtr_q] <= au_waddr;
            fifoData_q[wrPtr_q] <= au_wdata;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: single-cycle vector table plus hand-written starvation,
// WAW-kill, full-FIFO and flush sequences; every register-file write is scoreboarded.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        au_valid;
    logic        au_ready;
    logic [4:0]  au_waddr;
    logic [31:0] au_wdata;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int testsRun  = 0;
    int failCount = 0;
    logic monEn = 1'b0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t expQ[$];

    typedef struct {
        logic        pWe;
        logic [4:0]  pAddr;
        logic [31:0] pData;
        logic        aValid;
        logic [4:0]  aAddr;
        logic [31:0] aData;
        logic        fl;
        logic        expWe;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic        expReady;
        logic [31:0] expPending;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    rf_wport_arbiter #(
        .DEPTH(4),
        .STARVE_MAX(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pipe_we(pipe_we),
        .pipe_waddr(pipe_waddr),
        .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .au_valid(au_valid),
        .au_ready(au_ready),
        .au_waddr(au_waddr),
        .au_wdata(au_wdata),
        .flush(flush),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .pending(pending)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pWe, input logic [4:0] pAddr, input logic [31:0] pData,
                                 input logic aValid, input logic [4:0] aAddr, input logic [31:0] aData,
                                 input logic fl);
        pipe_we    = pWe;
        pipe_waddr = pAddr;
        pipe_wdata = pData;
        au_valid   = aValid;
        au_waddr   = aAddr;
        au_wdata   = aData;
        flush      = fl;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        expQ.push_back(w);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkQueueEmpty(input string name);
        checkOutput(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Every write the DUT makes must match the oldest expected write.
    always @(negedge clk) begin
        if (monEn && (rf_we !== 1'b0)) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL unexpectedWrite: got we=%b r%0d=0x%08h, expected no write",
                         rf_we, rf_waddr, rf_wdata);
            end else begin
                wr_t w;
                w = expQ.pop_front();
                checkOutput("rfWaddr", 32'(rf_waddr), 32'(w.addr));
                checkOutput("rfWdata", rf_wdata, w.data);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 5'd1, 32'hDEAD, 1'b1, 5'd2, 32'hBEEF, 1'b0);

        // Fields: pipe we/addr/data, au valid/addr/data, flush, exp we/addr/data, exp ready, exp pending
        vecs[0] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h11, 1'b0, 1'b1, 5'd5, 32'h11, 1'b1, 32'h0};
        vecs[1] = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 32'h0};
        vecs[4] = '{1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 32'h0};
        vecs[5] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h60, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0};
        vecs[6] = '{1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd2, 32'h22, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h99, 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 32'h0};
        vecs[8] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 32'h0};
        vecs[9] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 32'h0};

        // Reset held three cycles with both requesters active.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rstReady%0d", c), 32'(au_ready), 32'd0);
            checkOutput($sformatf("rstWe%0d", c), 32'(rf_we), 32'd0);
            checkOutput($sformatf("rstPending%0d", c), pending, 32'd0);
            checkOutput($sformatf("rstStall%0d", c), 32'(pipe_stall), 32'd0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        monEn = 1'b1;
        idleInputs();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].pWe, vecs[i].pAddr, vecs[i].pData,
                          vecs[i].aValid, vecs[i].aAddr, vecs[i].aData, vecs[i].fl);
            if (vecs[i].expWe) expectWrite(vecs[i].expAddr, vecs[i].expData);
            @(negedge clk);
            checkOutput($sformatf("vec%0dWe", i), 32'(rf_we), 32'(vecs[i].expWe));
            checkOutput($sformatf("vec%0dReady", i), 32'(au_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0dPending", i), pending, vecs[i].expPending);
            checkOutput($sformatf("vec%0dStall", i), 32'(pipe_stall), 32'd0);
            nextCycle();
            checkQueueEmpty($sformatf("vec%0dQueue", i));
        end

        // Starvation: r7 waits behind a busy pipe until the pipe is forced to stall.
        for (int c = 0; c <= 10; c++) begin
            applyStimulus(1'b1, 5'd3, 32'h300 + c, c == 0, 5'd7, 32'h77, 1'b0);
            if (c == 9) expectWrite(5'd7, 32'h77);
            else        expectWrite(5'd3, 32'h300 + c);
            @(negedge clk);
            checkOutput($sformatf("starveStall%0d", c), 32'(pipe_stall), (c == 9) ? 32'd1 : 32'd0);
            checkOutput($sformatf("starvePending%0d", c), pending,
                        (c >= 1 && c <= 9) ? 32'h80 : 32'h0);
            nextCycle();
        end
        checkQueueEmpty("starveQueue");

        // WAW kill: queued r9 is superseded by a younger pipe write of r9.
        applyStimulus(1'b1, 5'd3, 32'h1, 1'b1, 5'd9, 32'hA, 1'b0);
        expectWrite(5'd3, 32'h1);
        nextCycle();
        applyStimulus(1'b1, 5'd9, 32'hB, 1'b0, 5'd0, 32'h0, 1'b0);
        expectWrite(5'd9, 32'hB);
        @(negedge clk);
        checkOutput("wawPendingQueued", pending, 32'h200);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("wawDeadNoWrite", 32'(rf_we), 32'd0);
        checkOutput("wawPendingCleared", pending, 32'h0);
        nextCycle();
        nextCycle();
        checkQueueEmpty("wawQueue");

        // Fill the FIFO while the pipe keeps the port busy.
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 5'd1, 32'h100 + c, 1'b1, 5'(10 + c), 32'hA0 + c, 1'b0);
            expectWrite(5'd1, 32'h100 + c);
            @(negedge clk);
            checkOutput($sformatf("fillReady%0d", c), 32'(au_ready), (c < 4) ? 32'd1 : 32'd0);
            nextCycle();
        end
        idleInputs();
        expectWrite(5'd10, 32'hA0);
        @(negedge clk);
        checkOutput("fullPending", pending, 32'h3C00);
        checkOutput("fullReadyBeforePop", 32'(au_ready), 32'd0);
        nextCycle();
        expectWrite(5'd11, 32'hA1);
        @(negedge clk);
        checkOutput("fullReadyAfterPop", 32'(au_ready), 32'd1);
        checkOutput("fullPendingAfterPop", pending, 32'h3800);
        nextCycle();
        expectWrite(5'd12, 32'hA2);
        nextCycle();
        expectWrite(5'd13, 32'hA3);
        nextCycle();
        @(negedge clk);
        checkOutput("drainPending", pending, 32'h0);
        nextCycle();
        checkQueueEmpty("fillQueue");

        // Flush discards three queued results; the pipe write in the flush cycle still lands.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 5'd2, 32'h200 + c, 1'b1, 5'(20 + c), 32'hC0 + c, 1'b0);
            expectWrite(5'd2, 32'h200 + c);
            nextCycle();
        end
        applyStimulus(1'b1, 5'd2, 32'h2FF, 1'b1, 5'd25, 32'hC5, 1'b1);
        expectWrite(5'd2, 32'h2FF);
        @(negedge clk);
        checkOutput("flushPendingBefore", pending, 32'h700000);
        checkOutput("flushReady", 32'(au_ready), 32'd0);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("flushPendingAfter", pending, 32'h0);
        checkOutput("flushNoUnitWrite", 32'(rf_we), 32'd0);
        checkOutput("flushReadyAfter", 32'(au_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd26, 32'h66, 1'b0);
        expectWrite(5'd26, 32'h66);
        nextCycle();
        idleInputs();
        nextCycle();
        checkQueueEmpty("flushQueue");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
